// File: rtl/ara_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ara_pkg
// Description : Shared constants, typedefs and helpers for the AXI address
//               channel scheduler (ara_axi_addr_sched) and its counters.
//               The typedefs describe the default 2-requester configuration.
// Revision    : 1.0 - initial release
// ============================================================================
package ara_pkg;

    localparam int unsigned c_SCHED_NR_REQ          = 2;
    localparam int unsigned c_SCHED_MAX_OUTSTANDING = 8;
    localparam int unsigned c_SCHED_WEIGHT_WIDTH    = 4;
    localparam int unsigned c_SCHED_STARVE_LIMIT    = 32;

    // Index width that never collapses to zero bits, so a single-requester
    // build still has a legal one-bit select.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned c_SCHED_IDX_W = clog2_min1(c_SCHED_NR_REQ);
    localparam int unsigned c_SCHED_CNT_W = $clog2(c_SCHED_MAX_OUTSTANDING + 1);

    typedef logic [c_SCHED_IDX_W-1:0]        idx_t;
    typedef logic [c_SCHED_CNT_W-1:0]        cnt_t;
    typedef logic [c_SCHED_WEIGHT_WIDTH-1:0] weight_t;

endpackage
`default_nettype wire

// File: rtl/ara_sched_ctr.sv
`default_nettype none
// ============================================================================
// Module      : ara_sched_ctr
// Description : Saturating up/down counter with simultaneous increment and
//               decrement. A decrement at zero leaves the count at zero and
//               raises o_underflow for that cycle.
// Ports       : clk, rst     - clock, synchronous active-high reset
//               i_inc, i_dec - count up / count down requests
//               o_count      - current count
//               o_underflow  - decrement requested while count is zero
// Revision    : 1.0 - initial release
// ============================================================================
module ara_sched_ctr
    import ara_pkg::*;
#(
    parameter int unsigned MAX_COUNT = c_SCHED_MAX_OUTSTANDING,
    parameter int unsigned WIDTH     = $clog2(MAX_COUNT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [WIDTH-1:0] o_count,
    output logic             o_underflow
);

    localparam logic [WIDTH-1:0] c_MAX = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_count;

    // inc and dec together cancel out: a beat accepted in the same cycle as
    // a completion leaves the live count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_inc && !i_dec) begin
            if (r_count != c_MAX) begin
                r_count <= r_count + c_ONE;
            end
        end else if (i_dec && !i_inc) begin
            if (r_count != '0) begin
                r_count <= r_count - c_ONE;
            end
        end
    end

    assign o_count     = r_count;
    assign o_underflow = i_dec && !i_inc && (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/ara_axi_addr_sched.sv
`default_nettype none
// ============================================================================
// Module      : ara_axi_addr_sched
// Description : Weighted round-robin scheduler for one AXI address channel
//               (AR or AW) shared by CVA6 (index 0) and Ara (index 1).
//               Arbitrates combinationally in IDLE, locks the choice under
//               backpressure, caps outstanding transactions per requester and
//               force-grants requesters whose wait age reaches STARVE_LIMIT.
// Ports       : clk_i, rst_i   - clock, synchronous active-high reset
//               req_valid_i    - per-requester address beat pending
//               req_ready_o    - per-requester beat accepted
//               weight_i       - per-requester burst-credit weight (0 -> 1)
//               mst_valid_o    - valid toward mux/slave
//               mst_ready_i    - ready from mux/slave
//               sel_o          - requester driving the channel
//               done_valid_i   - one transaction completed
//               done_idx_i     - owner of the completed transaction
//               outstanding_o  - live outstanding count per requester
//               err_o          - sticky: completion seen with zero outstanding
// Revision    : 1.0 - initial release
// ============================================================================
module ara_axi_addr_sched
    import ara_pkg::*;
#(
    parameter int unsigned NR_REQ          = c_SCHED_NR_REQ,
    parameter int unsigned MAX_OUTSTANDING = c_SCHED_MAX_OUTSTANDING,
    parameter int unsigned WEIGHT_WIDTH    = c_SCHED_WEIGHT_WIDTH,
    parameter int unsigned STARVE_LIMIT    = c_SCHED_STARVE_LIMIT
) (
    input  logic                                            clk_i,
    input  logic                                            rst_i,
    input  logic [NR_REQ-1:0]                               req_valid_i,
    output logic [NR_REQ-1:0]                               req_ready_o,
    input  logic [NR_REQ*WEIGHT_WIDTH-1:0]                  weight_i,
    output logic                                            mst_valid_o,
    input  logic                                            mst_ready_i,
    output logic [clog2_min1(NR_REQ)-1:0]                   sel_o,
    input  logic                                            done_valid_i,
    input  logic [clog2_min1(NR_REQ)-1:0]                   done_idx_i,
    output logic [NR_REQ*$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding_o,
    output logic                                            err_o
);

    localparam int unsigned c_IDX_W = clog2_min1(NR_REQ);
    localparam int unsigned c_CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned c_AGE_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [c_CNT_W-1:0]      c_MAX_CNT = c_CNT_W'(MAX_OUTSTANDING);
    localparam logic [c_AGE_W-1:0]      c_STARVE  = c_AGE_W'(STARVE_LIMIT);
    localparam logic [c_AGE_W-1:0]      c_AGE_ONE = c_AGE_W'(1);
    localparam logic [WEIGHT_WIDTH-1:0] c_W_ONE   = WEIGHT_WIDTH'(1);

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_GRANT = 1'b1;

    logic [0:0]              r_state;
    logic [0:0]              w_state_next;
    logic [c_IDX_W-1:0]      r_ptr;
    logic [c_IDX_W-1:0]      r_lock;
    logic                    r_err;
    logic [WEIGHT_WIDTH-1:0] r_credit [NR_REQ];
    logic [c_AGE_W-1:0]      r_age    [NR_REQ];

    logic [WEIGHT_WIDTH-1:0] w_weight_raw  [NR_REQ];
    logic [WEIGHT_WIDTH-1:0] w_weight_eff  [NR_REQ];
    logic [WEIGHT_WIDTH-1:0] w_credit_next [NR_REQ];
    logic [c_CNT_W-1:0]      w_cnt         [NR_REQ];

    logic [NR_REQ-1:0] w_elig;
    logic [NR_REQ-1:0] w_hs_vec;
    logic [NR_REQ-1:0] w_done_vec;
    logic [NR_REQ-1:0] w_underflow;

    logic               w_starve_hit;
    logic [c_IDX_W-1:0] w_starve_idx;
    logic               w_rot_hit;
    logic [c_IDX_W-1:0] w_rot_idx;
    logic [c_IDX_W-1:0] w_rot_cand;
    logic               w_ptr_ok;
    logic [c_IDX_W-1:0] w_pick;
    logic               w_pick_reload;
    logic               w_arb;
    logic               w_mst_valid;
    logic [c_IDX_W-1:0] w_sel;
    logic               w_valid_out;
    logic               w_hs;

    // ------------------------------------------------------------------
    // Per-requester decode and outstanding tracking
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NR_REQ; g++) begin : g_req
        assign w_weight_raw[g] = weight_i[g*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        assign w_weight_eff[g] = (w_weight_raw[g] == '0) ? c_W_ONE : w_weight_raw[g];
        assign w_hs_vec[g]     = w_hs && (w_sel == c_IDX_W'(g));
        assign w_done_vec[g]   = done_valid_i && (done_idx_i == c_IDX_W'(g));
        // Uses the registered count, so a completion at the cap only
        // unmasks the requester from the following cycle.
        assign w_elig[g]       = req_valid_i[g] && (w_cnt[g] < c_MAX_CNT);

        ara_sched_ctr #(
            .MAX_COUNT (MAX_OUTSTANDING),
            .WIDTH     (c_CNT_W)
        ) u_ctr (
            .clk         (clk_i),
            .rst         (rst_i),
            .i_inc       (w_hs_vec[g]),
            .i_dec       (w_done_vec[g]),
            .o_count     (w_cnt[g]),
            .o_underflow (w_underflow[g])
        );

        assign outstanding_o[g*c_CNT_W +: c_CNT_W] = w_cnt[g];
    end

    // ------------------------------------------------------------------
    // Arbitration: starvation first, then the current pointer while it
    // still holds credit, otherwise rotate to the next eligible index.
    // ------------------------------------------------------------------
    always_comb begin
        w_starve_hit = 1'b0;
        w_starve_idx = '0;
        // Descending scan so the lowest starving index wins.
        for (int i = NR_REQ - 1; i >= 0; i--) begin
            if (w_elig[i] && (r_age[i] >= c_STARVE)) begin
                w_starve_hit = 1'b1;
                w_starve_idx = c_IDX_W'(i);
            end
        end

        w_rot_hit  = 1'b0;
        w_rot_idx  = '0;
        w_rot_cand = '0;
        // k = NR_REQ wraps back onto ptr itself, so a lone eligible
        // requester with exhausted credit still gets a reload.
        for (int k = NR_REQ; k >= 1; k--) begin
            w_rot_cand = c_IDX_W'((int'(r_ptr) + k) % int'(NR_REQ));
            if (w_elig[w_rot_cand]) begin
                w_rot_hit = 1'b1;
                w_rot_idx = w_rot_cand;
            end
        end

        w_ptr_ok = w_elig[r_ptr] && (r_credit[r_ptr] != '0);

        w_pick        = w_rot_idx;
        w_pick_reload = 1'b0;
        if (w_starve_hit) begin
            w_pick = w_starve_idx;
        end else if (w_ptr_ok) begin
            w_pick = r_ptr;
        end else begin
            w_pick_reload = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // IDLE / GRANT control
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_mst_valid  = 1'b0;
        w_sel        = '0;
        w_arb        = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_rot_hit) begin
                    w_arb       = 1'b1;
                    w_mst_valid = 1'b1;
                    w_sel       = w_pick;
                    if (!mst_ready_i) begin
                        w_state_next = c_ST_GRANT;
                    end
                end
            end
            c_ST_GRANT: begin
                w_mst_valid = 1'b1;
                w_sel       = r_lock;
                if (mst_ready_i) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    // Outputs are forced quiet while reset is asserted so nothing can
    // handshake on the reset edge.
    assign w_valid_out = w_mst_valid && !rst_i;
    assign w_hs        = w_valid_out && mst_ready_i;
    assign mst_valid_o = w_valid_out;
    assign sel_o       = rst_i ? '0 : w_sel;
    assign req_ready_o = w_hs_vec;
    assign err_o       = r_err;

    // Credit: reload on a rotating pick, then spend one on the handshake;
    // both can land on the same edge.
    always_comb begin
        for (int i = 0; i < NR_REQ; i++) begin
            w_credit_next[i] = r_credit[i];
            if (w_arb && w_pick_reload && (w_pick == c_IDX_W'(i))) begin
                w_credit_next[i] = w_weight_eff[i];
            end
            if (w_hs_vec[i] && (w_credit_next[i] != '0)) begin
                w_credit_next[i] = w_credit_next[i] - c_W_ONE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_ST_IDLE;
            r_ptr   <= '0;
            r_lock  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_arb) begin
                if (!mst_ready_i) begin
                    r_lock <= w_pick;
                end
                if (w_pick_reload) begin
                    r_ptr <= w_pick;
                end
            end
            if (|w_underflow) begin
                r_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NR_REQ; i++) begin
            if (rst_i) begin
                r_credit[i] <= '0;
                r_age[i]    <= '0;
            end else begin
                r_credit[i] <= w_credit_next[i];
                if (w_hs_vec[i]) begin
                    r_age[i] <= '0;
                end else if (w_elig[i] && (r_age[i] < c_STARVE)) begin
                    r_age[i] <= r_age[i] + c_AGE_ONE;
                end
            end
        end
    end

    // A locked requester must keep its beat pending until accepted.
    a_lock_held : assert property (
        @(posedge clk_i) disable iff (rst_i)
        (r_state == c_ST_GRANT) |-> req_valid_i[r_lock]
    );

endmodule
`default_nettype wire

// File: tb/tb_ara_axi_addr_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_ara_axi_addr_sched
// Description : Self-checking bench for ara_axi_addr_sched. Stimulus pushes
//               the hand-computed grant order into a queue; a monitor pops
//               and compares on every address handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ara_axi_addr_sched;
    import ara_pkg::*;

    localparam int unsigned NR_REQ  = 2;
    localparam int unsigned MAX_OUT = 8;
    localparam int unsigned WW      = 4;
    localparam int unsigned STARVE  = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NR_REQ-1:0]    req_valid = '0;
    logic [NR_REQ-1:0]    req_ready;
    logic [NR_REQ*WW-1:0] weight = '0;
    logic                 mst_valid;
    logic                 mst_ready = 1'b0;
    idx_t                 sel;
    logic                 done_valid = 1'b0;
    idx_t                 done_idx = '0;
    logic [2*$bits(cnt_t)-1:0] outstanding;
    logic                 err;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];

    ara_axi_addr_sched #(
        .NR_REQ          (NR_REQ),
        .MAX_OUTSTANDING (MAX_OUT),
        .WEIGHT_WIDTH    (WW),
        .STARVE_LIMIT    (STARVE)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .weight_i      (weight),
        .mst_valid_o   (mst_valid),
        .mst_ready_i   (mst_ready),
        .sel_o         (sel),
        .done_valid_i  (done_valid),
        .done_idx_i    (done_idx),
        .outstanding_o (outstanding),
        .err_o         (err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Scoreboard monitor: every handshake must match the next expected grant.
    always @(negedge clk) begin
        if (mst_valid && mst_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL grant_unexpected actual=sel%0d required=no_grant", sel);
            end else begin
                int e;
                e = exp_q.pop_front();
                if ((int'(sel) != e) || (req_ready != (2'b01 << e))) begin
                    failures++;
                    $display("FAIL grant actual=sel%0d/ready%b required=sel%0d/ready%b",
                             sel, req_ready, e, 2'b01 << e);
                end
            end
        end else begin
            checks++;
            if (req_ready != '0) begin
                failures++;
                $display("FAIL idle_ready actual=%b required=00", req_ready);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        req_valid  = '0;
        mst_ready  = 1'b0;
        done_valid = 1'b0;
        done_idx   = '0;
        @(negedge clk);
        chk("rst_mst_valid", 32'(mst_valid), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_sel", 32'(sel), 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_outstanding", 32'(outstanding), 0);
        chk("rst_err", 32'(err), 0);
        step();
    endtask

    initial begin
        // Weights {1,3}: grants 1,1,1,0 repeating.
        weight = {4'd3, 4'd1};
        do_reset();
        req_valid = 2'b11;
        mst_ready = 1'b1;
        foreach (exp_q[i]) exp_q.delete(i);
        exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(0);
        exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(0);
        repeat (8) step();
        req_valid = 2'b00;
        @(negedge clk);
        chk("wrr_outstanding", 32'(outstanding), 32'h62);
        step();
        done_valid = 1'b1;
        done_idx   = 1'b1;
        step();
        done_valid = 1'b0;
        @(negedge clk);
        chk("done_decrement", 32'(outstanding), 32'h52);
        step();

        // Backpressure: grant to 0 held 5 cycles, accepted on the 6th.
        weight = {4'd1, 4'd1};
        do_reset();
        req_valid = 2'b01;
        mst_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stall_valid", 32'(mst_valid), 1);
            chk("stall_sel", 32'(sel), 0);
            step();
            req_valid = 2'b11;
        end
        mst_ready = 1'b1;
        exp_q.push_back(0);
        exp_q.push_back(1);
        step();
        step();
        req_valid = 2'b00;
        @(negedge clk);
        chk("stall_outstanding", 32'(outstanding), 32'h11);
        step();

        // Outstanding cap: 8 grants, masked, done unmasks next cycle.
        do_reset();
        req_valid = 2'b01;
        mst_ready = 1'b1;
        repeat (8) exp_q.push_back(0);
        repeat (8) step();
        done_valid = 1'b1;
        done_idx   = 1'b0;
        @(negedge clk);
        chk("cap_masked", 32'(mst_valid), 0);
        chk("cap_count", 32'(outstanding), 32'h08);
        step();
        done_valid = 1'b0;
        exp_q.push_back(0);
        @(negedge clk);
        chk("cap_unmask", 32'(mst_valid), 1);
        step();
        req_valid = 2'b00;
        @(negedge clk);
        chk("cap_count_after", 32'(outstanding), 32'h08);
        step();

        // Starvation: weights {15,1}, limit 4.
        weight = {4'd1, 4'd15};
        do_reset();
        req_valid = 2'b11;
        mst_ready = 1'b1;
        exp_q.push_back(1);
        repeat (4) exp_q.push_back(0);
        exp_q.push_back(1);
        repeat (4) exp_q.push_back(0);
        exp_q.push_back(1);
        repeat (11) step();
        req_valid = 2'b00;
        @(negedge clk);
        chk("starve_outstanding", 32'(outstanding), 32'h38);
        step();

        // Underflow error and simultaneous handshake + done.
        weight = {4'd1, 4'd1};
        do_reset();
        done_valid = 1'b1;
        done_idx   = 1'b1;
        step();
        done_valid = 1'b0;
        @(negedge clk);
        chk("err_set", 32'(err), 1);
        chk("err_count", 32'(outstanding), 0);
        step();
        req_valid = 2'b01;
        mst_ready = 1'b1;
        repeat (3) exp_q.push_back(0);
        repeat (3) step();
        done_valid = 1'b1;
        done_idx   = 1'b0;
        exp_q.push_back(0);
        step();
        done_valid = 1'b0;
        req_valid  = 2'b00;
        @(negedge clk);
        chk("same_cycle_count", 32'(outstanding), 32'h03);
        chk("err_sticky", 32'(err), 1);
        step();

        // Reset while locked in GRANT with count 5.
        do_reset();
        req_valid = 2'b01;
        mst_ready = 1'b1;
        repeat (5) exp_q.push_back(0);
        repeat (5) step();
        mst_ready = 1'b0;
        @(negedge clk);
        chk("lock_pre_valid", 32'(mst_valid), 1);
        step();
        @(negedge clk);
        chk("lock_count", 32'(outstanding), 32'h05);
        chk("lock_valid", 32'(mst_valid), 1);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_valid", 32'(mst_valid), 0);
        chk("rst_mid_ready", 32'(req_ready), 0);
        chk("rst_mid_sel", 32'(sel), 0);
        step();
        rst       = 1'b0;
        req_valid = 2'b00;
        @(negedge clk);
        chk("post_rst_valid", 32'(mst_valid), 0);
        chk("post_rst_count", 32'(outstanding), 0);
        chk("post_rst_err", 32'(err), 0);
        step();
        req_valid = 2'b01;
        mst_ready = 1'b1;
        exp_q.push_back(0);
        step();
        req_valid = 2'b00;
        @(negedge clk);
        chk("post_rst_grant_count", 32'(outstanding), 32'h01);
        step();

        repeat (2) step();
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
